cnt_stream_capture: RTL and testbench
=====================================

Name: cnt_stream_capture

Overview:
- Downstream consumer of the 8-bit free-running counter and its 2-bit adder sum `cc`.
- Samples `{cc, cnt}` whenever the producer asserts `in_valid` and buffers the samples in a small first-word-fall-through FIFO.
- Presents the buffered samples on a valid/ready output port.
- Tracks counter wrap events and flags dropped samples for debug/observation logic further downstream.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low: asserting rst low clears all state immediately; release is synchronous to clk.
- in_valid  input  1  producer sample strobe.
- cnt  input  8  counter value to capture.
- cc  input  2  adder sum to capture.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_data  output  10  head entry: {cc, cnt}, with cc in bits [9:8].
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- overflow  output  1  sticky: a sample was dropped.
- wrap_cnt  output  4  number of accepted 8'hFF -> 8'h00 transitions, modulo 16.

Behaviour:
- Reset (rst low): values below apply asynchronously and are held while rst is low.
  - wr_ptr = rd_ptr = 0, occupancy = 0.
  - out_valid = 0, empty = 1, full = 0, overflow = 0, wrap_cnt = 0.
  - out_data = 10'h000.
  - prev_valid = 0 (no previous sample recorded).
  - Storage array contents are don't-care.
- pop = out_valid & out_ready.
- push = in_valid & (~full | pop). A sample offered while full is accepted only if a pop occurs in the same cycle.
- Drop: in_valid & full & ~pop.
  - Sample is discarded and overflow is set to 1.
  - overflow stays 1 until reset; no other clear path.
- Occupancy update per clock edge:
  - +1 on push only, -1 on pop only.
  - Unchanged when push and pop are both high or both low.
  - Range is 0..DEPTH; must never underflow or overflow.
- Pointer wrap: wr_ptr and rd_ptr wrap modulo DEPTH (AW bits). full/empty are derived from the occupancy counter, not from pointer compare.
- Latency: a sample pushed at edge N is visible with out_valid = 1 and out_data = {cc, cnt} after edge N (cycle N+1). This holds when empty, including the push-while-empty case.
- out_data:
  - Always equals the head entry when out_valid = 1.
  - Holds its last value when empty; it must not change while out_valid = 1 and out_ready = 0.
- out_valid = ~empty, driven combinationally from registered occupancy.
- Wrap detection (accepted samples only; dropped samples ignored):
  - prev_cnt and prev_valid are updated on every push.
  - wrap_cnt increments when push & prev_valid & prev_cnt == 8'hFF & cnt == 8'h00.
  - wrap_cnt rolls 15 -> 0.
- Simultaneous push and pop when occupancy == 1: the head advances to the new sample, out_valid stays 1, occupancy stays 1.
- Reset asserted mid-operation:
  - All buffered data is lost; outputs return to reset values asynchronously.
  - No pop is reported during reset, even if out_ready = 1.
- cc is captured unmodified; no width extension or arithmetic is performed on captured data.

Test Plan:
- Reset: drive rst low mid-stream with 3 entries stored -> out_valid = 0, empty = 1, overflow = 0, wrap_cnt = 0 before the next clk edge; after release, first push of cnt = 8'h05, cc = 2'b10 -> out_data = 10'h205 one cycle later.
- Fill/drain: out_ready = 0, push cnt = 1,2,3,4 -> full = 1 after 4th edge; then out_ready = 1 -> out_data sequence 001,002,003,004 (cc = 0); empty = 1 after 4 pops.
- Overflow: full, out_ready = 0, push cnt = 8'h09 -> sample dropped, overflow = 1, subsequent drain yields only the 4 original entries; overflow still 1 after drain.
- Full with concurrent pop: full, in_valid = 1 with cnt = 8'h0A, out_ready = 1 -> no drop, overflow unchanged, full stays 1, 0x0A emerges 4th in order.
- Wrap: stream cnt 8'hFE, 8'hFF, 8'h00, 8'h01 with continuous pop -> wrap_cnt = 1; repeat 16 wraps -> wrap_cnt = 0. Also drop the 8'h00 sample while full -> wrap_cnt unchanged.
- Backpressure stability: out_valid = 1, toggle out_ready = 0 for 5 cycles while pushing 2 samples -> out_data constant, occupancy increments by 2, head unchanged.

Source files
------------

// File: rtl/cnt_stream_capture.sv
// Captures {cc, cnt} samples from the counter/adder producer into a small
// first-word-fall-through FIFO, and tracks counter wraps and dropped samples.
module cnt_stream_capture #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] cnt,
    input  logic [1:0] cc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic [3:0] wrap_cnt
);

    localparam logic [AW:0]   OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   occ_q;
    logic [AW:0]   occ_d;
    logic [9:0]    head_q;
    logic [9:0]    head_d;
    logic          ovf_q;
    logic          prev_valid_q;
    logic [7:0]    prev_cnt_q;
    logic [3:0]    wrap_q;

    logic          push;
    logic          pop;
    logic          wrap_hit;
    logic [9:0]    wdata;

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OCC_FULL);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);
    assign wdata     = {cc, cnt};
    assign wrap_hit  = push & prev_valid_q & (prev_cnt_q == 8'hFF) & (cnt == 8'h00);

    assign out_data  = head_q;
    assign overflow  = ovf_q;
    assign wrap_cnt  = wrap_q;

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    // The head is kept in its own register so it holds its last value once
    // the FIFO drains, and a push into an empty FIFO appears one edge later.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (occ_q > OCC_ONE) begin
                head_d = mem_q[rd_ptr_q + PTR_ONE];
            end else if (push) begin
                head_d = wdata;
            end
        end else if (push && empty) begin
            head_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            head_q       <= '0;
            ovf_q        <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_cnt_q   <= '0;
            wrap_q       <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            if (push) begin
                wr_ptr_q     <= wr_ptr_q + PTR_ONE;
                prev_valid_q <= 1'b1;
                prev_cnt_q   <= cnt;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (in_valid && !push) begin
                ovf_q <= 1'b1;
            end
            if (wrap_hit) begin
                wrap_q <= wrap_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cnt_stream_capture.sv
// Bench for cnt_stream_capture: a queue-based reference model compared every
// cycle, plus directed sequences with literal expectations.
module tb_cnt_stream_capture;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic [7:0] cntIn;
    logic [1:0] ccIn;
    logic       outValid;
    logic       outReady;
    logic [9:0] outData;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [3:0] wrapCnt;

    int checks;
    int errors;

    cnt_stream_capture #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inValid),
        .cnt      (cntIn),
        .cc       (ccIn),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data (outData),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .wrap_cnt (wrapCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of accepted samples plus sticky drop flag,
    // wrap count and the last head seen.
    logic [9:0] mq[$];
    logic       mOvf;
    int         mWrap;
    logic       mPrevValid;
    logic [7:0] mPrevCnt;
    logic [9:0] mHead;
    logic       mPush;
    logic       mPop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mOvf       = 1'b0;
            mWrap      = 0;
            mPrevValid = 1'b0;
            mPrevCnt   = 8'h00;
            mHead      = 10'h000;
        end else begin
            mPop  = (mq.size() != 0) && outReady;
            mPush = inValid && ((mq.size() < DEPTH) || mPop);
            if (inValid && !mPush) mOvf = 1'b1;
            if (mPush) begin
                if (mPrevValid && mPrevCnt == 8'hFF && cntIn == 8'h00) mWrap = (mWrap + 1) % 16;
                mPrevValid = 1'b1;
                mPrevCnt   = cntIn;
            end
            if (mPop) void'(mq.pop_front());
            if (mPush) mq.push_back({ccIn, cntIn});
            if (mq.size() != 0) mHead = mq[0];
        end
    end

    task automatic checkOutput(input string name, input logic [9:0] actual, input logic [9:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("m_out_valid", {9'b0, outValid}, {9'b0, mq.size() != 0});
        checkOutput("m_empty", {9'b0, empty}, {9'b0, mq.size() == 0});
        checkOutput("m_full", {9'b0, full}, {9'b0, mq.size() == DEPTH});
        checkOutput("m_overflow", {9'b0, overflow}, {9'b0, mOvf});
        checkOutput("m_wrap_cnt", {6'b0, wrapCnt}, 10'(mWrap));
        checkOutput("m_out_data", outData, mHead);
    end

    // Drives one cycle of inputs at a falling edge and returns at the next one.
    task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [7:0] n, input logic r);
        inValid  = v;
        ccIn     = c;
        cntIn    = n;
        outReady = r;
        @(negedge clk);
    endtask

    task automatic drainFour(input string name, input logic [9:0] e0, input logic [9:0] e1,
                             input logic [9:0] e2, input logic [9:0] e3);
        logic [9:0] exp4 [4];
        exp4[0] = e0; exp4[1] = e1; exp4[2] = e2; exp4[3] = e3;
        for (int i = 0; i < 4; i++) begin
            checkOutput(name, outData, exp4[i]);
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        end
        checkOutput({name, "_empty"}, {9'b0, empty}, 10'h001);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        inValid  = 1'b0;
        ccIn     = 2'd0;
        cntIn    = 8'h00;
        outReady = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_empty", {9'b0, empty}, 10'h001);
        checkOutput("rst_data", outData, 10'h000);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] fill and drain");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 2'd0, 8'(i), 1'b0);
        checkOutput("fill_full", {9'b0, full}, 10'h001);
        drainFour("fill_drain", 10'h001, 10'h002, 10'h003, 10'h004);

        $display("[TB] full with concurrent pop");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 2'd1, 8'(8'h10 + i), 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h0A, 1'b1);
        checkOutput("fcp_full", {9'b0, full}, 10'h001);
        checkOutput("fcp_ovf", {9'b0, overflow}, 10'h000);
        drainFour("fcp_drain", 10'h112, 10'h113, 10'h114, 10'h00A);

        $display("[TB] overflow");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 2'd2, 8'(8'h20 + i), 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h09, 1'b0);
        checkOutput("ovf_set", {9'b0, overflow}, 10'h001);
        drainFour("ovf_drain", 10'h221, 10'h222, 10'h223, 10'h224);
        checkOutput("ovf_sticky", {9'b0, overflow}, 10'h001);

        $display("[TB] wrap");
        applyStimulus(1'b1, 2'd0, 8'hFE, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'hFF, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'h01, 1'b1);
        checkOutput("wrap_one", {6'b0, wrapCnt}, 10'h001);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'hFC, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'hFD, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'hFE, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'hFF, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h00, 1'b0);
        checkOutput("wrap_drop", {6'b0, wrapCnt}, 10'h001);
        drainFour("wrap_drain", 10'h0FC, 10'h0FD, 10'h0FE, 10'h0FF);
        applyStimulus(1'b1, 2'd0, 8'h00, 1'b0);
        checkOutput("wrap_after_drop", {6'b0, wrapCnt}, 10'h002);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 2'd0, 8'hFF, 1'b1);
            applyStimulus(1'b1, 2'd0, 8'h00, 1'b1);
        end
        checkOutput("wrap_roll", {6'b0, wrapCnt}, 10'h000);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 2'd3, 8'h31, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h32, 1'b0);
        checkOutput("bp_hold", outData, 10'h331);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("bp_hold", outData, 10'h331);
        applyStimulus(1'b1, 2'd3, 8'h33, 1'b0);
        checkOutput("bp_hold", outData, 10'h331);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("bp_hold", outData, 10'h331);
        checkOutput("bp_not_full", {9'b0, full}, 10'h000);
        for (int i = 1; i <= 3; i++) begin
            checkOutput("bp_drain", outData, 10'h330 + 10'(i));
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        end
        checkOutput("bp_empty", {9'b0, empty}, 10'h001);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 2'd0, 8'hFF, 1'b0);
        applyStimulus(1'b1, 2'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, 2'd1, 8'h41, 1'b0);
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput("pre_rst_wrap", {6'b0, wrapCnt}, 10'h001);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {9'b0, outValid}, 10'h000);
        checkOutput("mid_rst_empty", {9'b0, empty}, 10'h001);
        checkOutput("mid_rst_ovf", {9'b0, overflow}, 10'h000);
        checkOutput("mid_rst_wrap", {6'b0, wrapCnt}, 10'h000);
        checkOutput("mid_rst_data", outData, 10'h000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 2'd2, 8'h05, 1'b0);
        checkOutput("post_rst_data", outData, 10'h205);
        checkOutput("post_rst_valid", {9'b0, outValid}, 10'h001);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
